// File: rtl/datapath.sv
// Single-cycle 16-bit core: fixed ROM program, 8x16 register file, ALU, branch, hex display of PC/R1..R7.
// One instruction retires per clk; display is combinational from current state; no backpressure.
module datapath (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] sw,
    output logic [6:0] seg0,
    output logic [6:0] seg1,
    output logic [6:0] seg2,
    output logic [6:0] seg3
);

    logic [7:0]  pc;
    logic [7:0]  pc_next;
    logic [15:0] regs [8];
    logic [15:0] instr;

    logic [3:0]  op;
    logic [2:0]  rd;
    logic [2:0]  rs;
    logic [2:0]  rt;
    logic [15:0] rd_val;
    logic [15:0] rs_val;
    logic [15:0] rt_val;
    logic [15:0] imm6_sext;
    logic        wr_en;
    logic [15:0] wr_dat;
    logic [15:0] disp_val;

    always_comb begin
        case (pc)
            8'd0:    instr = 16'h7205;
            8'd1:    instr = 16'h7403;
            8'd2:    instr = 16'h1650;
            8'd3:    instr = 16'h2850;
            8'd4:    instr = 16'h6B41;
            8'd5:    instr = 16'hB004;
            default: instr = 16'h0000;
        endcase
    end

    assign op        = instr[15:12];
    assign rd        = instr[11:9];
    assign rs        = instr[8:6];
    assign rt        = instr[5:3];
    assign imm6_sext = {{10{instr[5]}}, instr[5:0]};

    // regs[0] is held at zero by never being written, so R0 reads need no special case.
    assign rd_val = regs[rd];
    assign rs_val = regs[rs];
    assign rt_val = regs[rt];

    always_comb begin
        wr_en   = 1'b0;
        wr_dat  = 16'h0000;
        pc_next = pc + 8'd1;
        case (op)
            4'h1: begin wr_en = 1'b1; wr_dat = rs_val + rt_val;   end
            4'h2: begin wr_en = 1'b1; wr_dat = rs_val - rt_val;   end
            4'h3: begin wr_en = 1'b1; wr_dat = rs_val & rt_val;   end
            4'h4: begin wr_en = 1'b1; wr_dat = rs_val | rt_val;   end
            4'h5: begin wr_en = 1'b1; wr_dat = rs_val ^ rt_val;   end
            4'h6: begin wr_en = 1'b1; wr_dat = rs_val + imm6_sext; end
            4'h7: begin wr_en = 1'b1; wr_dat = {7'd0, instr[8:0]}; end
            4'h8: begin wr_en = 1'b1; wr_dat = rs_val << 1;       end
            4'h9: begin wr_en = 1'b1; wr_dat = rs_val >> 1;       end
            4'hA: begin
                if (rd_val == rs_val)
                    pc_next = pc + 8'd1 + imm6_sext[7:0];
            end
            4'hB: pc_next = instr[7:0];
            4'hF: pc_next = pc;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc <= 8'd0;
            for (int i = 0; i < 8; i++)
                regs[i] <= 16'h0000;
        end else begin
            pc <= pc_next;
            if (wr_en && rd != 3'd0)
                regs[rd] <= wr_dat;
        end
    end

    function automatic logic [6:0] hex7(input logic [3:0] d);
        case (d)
            4'h0: hex7 = 7'h40;
            4'h1: hex7 = 7'h79;
            4'h2: hex7 = 7'h24;
            4'h3: hex7 = 7'h30;
            4'h4: hex7 = 7'h19;
            4'h5: hex7 = 7'h12;
            4'h6: hex7 = 7'h02;
            4'h7: hex7 = 7'h78;
            4'h8: hex7 = 7'h00;
            4'h9: hex7 = 7'h10;
            4'hA: hex7 = 7'h08;
            4'hB: hex7 = 7'h03;
            4'hC: hex7 = 7'h46;
            4'hD: hex7 = 7'h21;
            4'hE: hex7 = 7'h06;
            default: hex7 = 7'h0E;
        endcase
    endfunction

    assign disp_val = (sw == 3'd0) ? {8'h00, pc} : regs[sw];

    assign seg0 = hex7(disp_val[3:0]);
    assign seg1 = hex7(disp_val[7:4]);
    assign seg2 = hex7(disp_val[11:8]);
    assign seg3 = hex7(disp_val[15:12]);

endmodule

// File: tb/tb_datapath.sv
// Bench for datapath: expected display values come from a closed-form model of the fixed program trace.
module tb_datapath;

    logic       clk;
    logic       rst;
    logic [2:0] sw;
    logic [6:0] seg0;
    logic [6:0] seg1;
    logic [6:0] seg2;
    logic [6:0] seg3;

    int checks;
    int errors;
    int e;      // rising edges since the last reset release

    datapath dut (
        .clk  (clk),
        .rst  (rst),
        .sw   (sw),
        .seg0 (seg0),
        .seg1 (seg1),
        .seg2 (seg2),
        .seg3 (seg3)
    );

    // Program state after n edges: LDI/LDI/ADD/SUB fill R1..R4, then the ADDI/JMP loop bumps R5 every other edge.
    function automatic logic [15:0] model_val(input int n, input int s);
        int v;
        v = 0;
        case (s)
            0: v = (n < 5) ? n : ((n % 2 == 1) ? 5 : 4);
            1: v = (n >= 1) ? 5 : 0;
            2: v = (n >= 2) ? 3 : 0;
            3: v = (n >= 3) ? 8 : 0;
            4: v = (n >= 4) ? 2 : 0;
            5: v = (n >= 5) ? (n - 3) / 2 : 0;
            default: v = 0;
        endcase
        return v[15:0];
    endfunction

    function automatic logic [6:0] seg_of(input logic [3:0] d);
        logic [6:0] tab [16];
        tab = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
        return tab[d];
    endfunction

    task automatic tick();
        #5 clk = 1'b1;
        #5 clk = 1'b0;
    endtask

    task automatic check_model(input int s, input string tag);
        logic [15:0] v;
        logic [27:0] exp;
        logic [27:0] got;
        sw = s[2:0];
        #1;
        v   = model_val(e, s);
        exp = {seg_of(v[15:12]), seg_of(v[11:8]), seg_of(v[7:4]), seg_of(v[3:0])};
        got = {seg3, seg2, seg1, seg0};
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s sw=%0d edge=%0d segs=%h expected=%h (value %h)", tag, s, e, got, exp, v);
        end
    endtask

    task automatic check_const(input int s, input logic [27:0] exp, input string tag);
        logic [27:0] got;
        sw = s[2:0];
        #1;
        got = {seg3, seg2, seg1, seg0};
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s sw=%0d edge=%0d segs=%h expected=%h", tag, s, e, got, exp);
        end
    endtask

    task automatic run_to(input int target);
        while (e < target) begin
            tick();
            e++;
            check_model($urandom_range(0, 7), "run");
        end
    endtask

    task automatic async_reset(input string tag);
        rst = 1'b0;
        #1;
        e = 0;
        for (int s = 0; s < 8; s++)
            check_model(s, tag);
        #1 rst = 1'b1;
        #1;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        e      = 0;
        clk    = 1'b0;
        rst    = 1'b0;
        sw     = 3'd0;
        #3;

        // Reset held across two clock edges
        tick();
        tick();
        check_const(0, {7'h40, 7'h40, 7'h40, 7'h40}, "reset_pc");
        for (int s = 0; s < 8; s++)
            check_model(s, "reset_all");
        #2 rst = 1'b1;
        #2;

        // Bring-up
        run_to(5);
        check_const(1, {7'h40, 7'h40, 7'h40, 7'h12}, "r1_0005");
        check_const(3, {7'h40, 7'h40, 7'h40, 7'h00}, "r3_0008");
        check_const(4, {7'h40, 7'h40, 7'h40, 7'h24}, "r4_0002");

        // Async reset mid-run, then trace restarts
        run_to(12);
        async_reset("midrun_reset");
        check_const(0, {7'h40, 7'h40, 7'h40, 7'h40}, "midrun_pc0");
        run_to(5);
        check_const(5, {7'h40, 7'h40, 7'h40, 7'h79}, "restart_r5_1");

        // Loop and combinational select
        run_to(25);
        check_const(5, {7'h40, 7'h40, 7'h40, 7'h03}, "r5_000b");
        check_const(0, {7'h40, 7'h40, 7'h40, 7'h12}, "pc_5");
        for (int s = 0; s < 8; s++)
            check_model(s, "sw_sweep");
        for (int s = 7; s >= 0; s--)
            check_model(s, "sw_sweep_back");
        tick();
        e++;
        check_const(0, {7'h40, 7'h40, 7'h40, 7'h19}, "pc_4");
        check_model(5, "r5_after_sweep");

        // Digit boundary 0x000F -> 0x0010
        run_to(33);
        check_const(5, {7'h40, 7'h40, 7'h40, 7'h0E}, "r5_000f");
        run_to(35);
        check_const(5, {7'h40, 7'h40, 7'h79, 7'h40}, "r5_0010");

        // Randomised run lengths with asynchronous resets in between
        for (int k = 0; k < 6; k++) begin
            run_to(e + $urandom_range(1, 60));
            async_reset("rand_reset");
        end
        run_to(40);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
